sao_lcu_feeder: RTL and testbench

//  Source side of the SAO pixel-input interface. Reads a 128x128 frame (LCU-major order) from a sync image ROM and
//  per-LCU parameters from a param ROM, then streams one pixel per beat to SAO with lcu_x/lcu_y/sao_* sideband.

---
 rtl/sao_lcu_feeder.sv | 242 ++++++++++++++++++++++++
 tb/tb_sao_lcu_feeder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sao_lcu_feeder.sv
// SAO pixel-input source: streams a frame from the image ROM in LCU-major order, one pixel per beat,
// with per-LCU SAO parameters and LCU coordinates as sideband, honouring busy backpressure.
module sao_lcu_feeder #(
    parameter int unsigned IMG_W  = 128,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned PAR_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        lcu_size_in,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [7:0]        img_rdata,
    output logic [PAR_W-1:0]  par_addr,
    input  logic [23:0]       par_rdata,
    input  logic              busy,
    output logic              in_en,
    output logic [7:0]        din,
    output logic [1:0]        sao_type,
    output logic [4:0]        sao_band_pos,
    output logic              sao_eo_class,
    output logic [15:0]       sao_offset,
    output logic [2:0]        lcu_x,
    output logic [2:0]        lcu_y,
    output logic [1:0]        lcu_size,
    output logic              done
);

    localparam int unsigned      CNT_W    = ADDR_W + 1;
    localparam int unsigned      IMG_LOG  = $clog2(IMG_W);
    localparam int unsigned      NPIX     = IMG_W * IMG_W;
    localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(NPIX);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);
    localparam logic [PAR_W-1:0] NL_LAST0 = PAR_W'(NPIX / 256 - 1);
    localparam logic [PAR_W-1:0] NL_LAST1 = PAR_W'(NPIX / 1024 - 1);
    localparam logic [PAR_W-1:0] NL_LAST2 = PAR_W'(NPIX / 4096 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_LOAD,
        S_STREAM,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_rd_idx;
    logic               r_issue;
    logic               r_rd_vld;
    logic [7:0]         r_skid0;
    logic [7:0]         r_skid1;
    logic [1:0]         r_skid_cnt;
    logic [11:0]        r_out_cnt;
    logic [PAR_W-1:0]   r_lcu_n;
    logic [CNT_W-1:0]   r_ld_idx;
    logic               r_out_last;
    logic               r_par_req;
    logic               r_par_rd;
    logic [23:0]        r_shadow;
    logic               r_shadow_vld;

    logic               w_accept;
    logic               w_avail;
    logic               w_first;
    logic               w_load;
    logic               w_push;
    logic               w_pop;
    logic [7:0]         w_pix;
    logic [2:0]         w_pend;
    logic               w_issue;
    logic [11:0]        w_p_last;
    logic [PAR_W-1:0]   w_nl_last;
    logic [2:0]         w_r_log;
    logic [2:0]         w_lcu_x;
    logic [2:0]         w_lcu_y;
    logic [1:0]         w_code_in;

    // Handshake, skid-buffer bookkeeping and LCU geometry for the latched size code.
    always_comb begin
        w_accept  = in_en && !busy;
        w_avail   = (r_skid_cnt != 2'd0) || r_rd_vld;
        w_first   = (r_out_cnt == 12'd0);
        w_load    = (r_state == S_STREAM) && (!in_en || w_accept) && w_avail
                    && (!w_first || r_shadow_vld);
        w_pop     = w_load && (r_skid_cnt != 2'd0);
        w_push    = r_rd_vld && !(w_load && (r_skid_cnt == 2'd0));
        w_pix     = (r_skid_cnt != 2'd0) ? r_skid0 : img_rdata;
        // Reads in flight plus buffered pixels may never exceed the two skid slots.
        w_pend    = 3'(r_skid_cnt) + 3'(r_rd_vld) + 3'(r_issue);
        w_issue   = ((r_state == S_PRIME) || (r_state == S_LOAD) || (r_state == S_STREAM))
                    && (r_rd_idx < TOTAL) && (w_pend < (3'd2 + 3'(w_load)));
        w_code_in = (lcu_size_in == 2'd3) ? 2'd0 : lcu_size_in;
        w_p_last  = 12'd4095;
        w_nl_last = NL_LAST2;
        case (lcu_size)
            2'd0: begin
                w_p_last  = 12'd255;
                w_nl_last = NL_LAST0;
            end
            2'd1: begin
                w_p_last  = 12'd1023;
                w_nl_last = NL_LAST1;
            end
            default: begin
                w_p_last  = 12'd4095;
                w_nl_last = NL_LAST2;
            end
        endcase
        w_r_log = 3'(IMG_LOG - 4) - 3'(lcu_size);
        w_lcu_x = 3'(r_lcu_n & ((PAR_W'(1) << w_r_log) - PAR_W'(1)));
        w_lcu_y = 3'(r_lcu_n >> w_r_log);
    end

    // Frame sequencing, ROM read pipeline, skid buffer and registered output beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_rd_idx     <= '0;
            r_issue      <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_skid0      <= '0;
            r_skid1      <= '0;
            r_skid_cnt   <= '0;
            r_out_cnt    <= '0;
            r_lcu_n      <= '0;
            r_ld_idx     <= '0;
            r_out_last   <= 1'b0;
            r_par_req    <= 1'b0;
            r_par_rd     <= 1'b0;
            r_shadow     <= '0;
            r_shadow_vld <= 1'b0;
            img_addr     <= '0;
            par_addr     <= '0;
            in_en        <= 1'b0;
            din          <= '0;
            sao_type     <= '0;
            sao_band_pos <= '0;
            sao_eo_class <= 1'b0;
            sao_offset   <= '0;
            lcu_x        <= '0;
            lcu_y        <= '0;
            lcu_size     <= '0;
            done         <= 1'b0;
        end else begin
            done      <= 1'b0;
            r_issue   <= w_issue;
            r_rd_vld  <= r_issue;
            r_par_req <= 1'b0;
            r_par_rd  <= r_par_req;

            if (w_issue) begin
                img_addr <= r_rd_idx[ADDR_W-1:0];
                r_rd_idx <= r_rd_idx + CNT_W'(1);
            end

            case ({w_push, w_pop})
                2'b10: begin
                    if (r_skid_cnt == 2'd0) r_skid0 <= img_rdata;
                    else                    r_skid1 <= img_rdata;
                    r_skid_cnt <= r_skid_cnt + 2'd1;
                end
                2'b01: begin
                    r_skid0    <= r_skid1;
                    r_skid_cnt <= r_skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_skid_cnt == 2'd1) begin
                        r_skid0 <= img_rdata;
                    end else begin
                        r_skid0 <= r_skid1;
                        r_skid1 <= img_rdata;
                    end
                end
                default: ;
            endcase

            if (w_load) begin
                in_en      <= 1'b1;
                din        <= w_pix;
                r_ld_idx   <= r_ld_idx + CNT_W'(1);
                r_out_last <= (r_ld_idx == LAST_IDX);
                if (r_out_cnt == w_p_last) begin
                    r_out_cnt <= '0;
                    r_lcu_n   <= r_lcu_n + PAR_W'(1);
                end else begin
                    r_out_cnt <= r_out_cnt + 12'd1;
                end
                // First pixel of an LCU switches sideband and prefetches the next LCU's params.
                if (w_first) begin
                    sao_type     <= r_shadow[23:22];
                    sao_band_pos <= r_shadow[21:17];
                    sao_eo_class <= r_shadow[16];
                    sao_offset   <= r_shadow[15:0];
                    lcu_x        <= w_lcu_x;
                    lcu_y        <= w_lcu_y;
                    r_shadow_vld <= 1'b0;
                    if (r_lcu_n != w_nl_last) begin
                        par_addr  <= r_lcu_n + PAR_W'(1);
                        r_par_req <= 1'b1;
                    end
                end
            end else if (w_accept) begin
                in_en <= 1'b0;
            end

            if (r_par_rd) begin
                r_shadow     <= par_rdata;
                r_shadow_vld <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_PRIME;
                        lcu_size     <= w_code_in;
                        img_addr     <= '0;
                        par_addr     <= '0;
                        r_issue      <= 1'b1;
                        r_rd_idx     <= CNT_W'(1);
                        r_par_req    <= 1'b1;
                        r_out_cnt    <= '0;
                        r_lcu_n      <= '0;
                        r_ld_idx     <= '0;
                        r_out_last   <= 1'b0;
                        r_shadow_vld <= 1'b0;
                    end
                end
                S_PRIME:  r_state <= S_LOAD;
                S_LOAD:   r_state <= S_STREAM;
                S_STREAM: begin
                    if (w_accept && r_out_last) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end
                end
                S_DONE:   r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sao_lcu_feeder.sv
// Bench for sao_lcu_feeder: ROM models, expected-beat scoreboard filled at start, and a monitor that
// checks every accepted beat, sideband stability under stall and done timing.
module tb_sao_lcu_feeder;

    localparam int T = 16384;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  lcu_size_in;
    logic [13:0] img_addr;
    logic [7:0]  img_rdata;
    logic [5:0]  par_addr;
    logic [23:0] par_rdata;
    logic        busy;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  sao_type;
    logic [4:0]  sao_band_pos;
    logic        sao_eo_class;
    logic [15:0] sao_offset;
    logic [2:0]  lcu_x;
    logic [2:0]  lcu_y;
    logic [1:0]  lcu_size;
    logic        done;

    typedef struct packed {
        logic [7:0]  din;
        logic [1:0]  typ;
        logic [4:0]  band;
        logic        eo;
        logic [15:0] off;
        logic [2:0]  x;
        logic [2:0]  y;
    } beat_t;

    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    beats   = 0;
    int    done_cnt = 0;
    int    stall_last = 0;
    int    stall_cnt = 0;
    int    bmode = 0;
    beat_t snap256, snap1024, snap2048, snap_last;

    sao_lcu_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .lcu_size_in  (lcu_size_in),
        .img_addr     (img_addr),
        .img_rdata    (img_rdata),
        .par_addr     (par_addr),
        .par_rdata    (par_rdata),
        .busy         (busy),
        .in_en        (in_en),
        .din          (din),
        .sao_type     (sao_type),
        .sao_band_pos (sao_band_pos),
        .sao_eo_class (sao_eo_class),
        .sao_offset   (sao_offset),
        .lcu_x        (lcu_x),
        .lcu_y        (lcu_y),
        .lcu_size     (lcu_size),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pix_fn(input int i);
        return 8'((i * 37) ^ (i >> 8));
    endfunction

    function automatic logic [23:0] par_fn(input int n);
        return {2'(n % 3), 5'(n * 5 + 3), 1'(n >> 1), 16'(n * 1021 + 4660)};
    endfunction

    // Synchronous ROMs with one cycle of read latency.
    always @(posedge clk) begin
        img_rdata <= pix_fn(int'(img_addr));
        par_rdata <= par_fn(int'(par_addr));
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int code);
        int s, p, r, n;
        logic [23:0] pv;
        beat_t e;
        s = 16 << code;
        p = s * s;
        r = 128 / s;
        for (int i = 0; i < T; i++) begin
            n  = i / p;
            pv = par_fn(n);
            e.din  = pix_fn(i);
            e.typ  = pv[23:22];
            e.band = pv[21:17];
            e.eo   = pv[16];
            e.off  = pv[15:0];
            e.x    = 3'(n % r);
            e.y    = 3'(n / r);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: pop and compare on every accepted beat; check hold under stall and done timing.
    logic  hold_v   = 1'b0;
    logic  last_acc = 1'b0;
    beat_t held;
    beat_t cur;
    beat_t mon_exp;
    always @(negedge clk) begin
        cur = {din, sao_type, sao_band_pos, sao_eo_class, sao_offset, lcu_x, lcu_y};
        if (!reset) begin
            hold_v   = 1'b0;
            last_acc = 1'b0;
        end else begin
            if (hold_v)
                chk("stall_hold", 64'({in_en, cur}), 64'({1'b1, held}));
            if (done) begin
                done_cnt++;
                chk("done_in_en", 64'(in_en), 64'(0));
                chk("done_after_last", 64'(last_acc), 64'(1));
            end
            last_acc = 1'b0;
            if (in_en && !busy) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'(cur), 64'(0));
                    n_fail += (cur == '0) ? 1 : 0;
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk($sformatf("beat%0d", beats), 64'(cur), 64'(mon_exp));
                    if (exp_q.size() == 0) begin
                        last_acc  = 1'b1;
                        snap_last = cur;
                    end
                end
                if (beats == 256)  snap256  = cur;
                if (beats == 1024) snap1024 = cur;
                if (beats == 2048) snap2048 = cur;
                beats++;
            end
            if (in_en && busy && beats == T - 1) stall_last++;
            hold_v = in_en && busy;
            held   = cur;
        end
    end

    // Backpressure driver, changed just after each rising edge.
    initial begin
        busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (bmode)
                1: busy = (beats < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
                2: begin
                    if (beats == T - 1 && stall_cnt < 10) begin
                        busy = 1'b1;
                        stall_cnt++;
                    end else begin
                        busy = 1'b0;
                    end
                end
                default: busy = 1'b0;
            endcase
        end
    end

    task automatic start_frame(input int code);
        beats      = 0;
        done_cnt   = 0;
        stall_last = 0;
        stall_cnt  = 0;
        push_frame(code);
        lcu_size_in = 2'(code);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (done || cyc >= limit) break;
            cyc++;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'(1));
    endtask

    task automatic end_checks(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
        chk({tag, "_beats"}, 64'(beats), 64'(T));
        chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
        chk({tag, "_in_en_idle"}, 64'(in_en), 64'(0));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int cyc;
        int guard;
        reset = 1'b0;
        start = 1'b1;
        lcu_size_in = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({img_addr, par_addr, in_en, din, sao_type, sao_band_pos,
            sao_eo_class, sao_offset, lcu_x, lcu_y, lcu_size, done}), 64'(0));
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Frame A: 16x16, no backpressure, stray start mid-stream.
        bmode = 0;
        start_frame(0);
        lat = 0;
        forever begin
            @(negedge clk);
            if (in_en || lat >= 10) break;
            @(posedge clk);
            lat++;
        end
        chk("A_first_latency", 64'(lat), 64'(3));
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (cyc == 500) begin
                #1;
                start = 1'b1;
                lcu_size_in = 2'd2;
            end
            if (cyc == 501) begin
                #1;
                start = 1'b0;
                lcu_size_in = 2'd0;
            end
            @(negedge clk);
            if (done || cyc > T + 100) break;
        end
        chk("A_done_seen", 64'(done), 64'(1));
        chk("A_cycles", 64'(cyc), 64'(T));
        end_checks("A");
        chk("A_lcu_size", 64'(lcu_size), 64'(0));
        chk("A_b256_xy", 64'({snap256.x, snap256.y}), 64'({3'd1, 3'd0}));
        chk("A_b256_par", 64'({snap256.typ, snap256.band, snap256.eo, snap256.off}), 64'(par_fn(1)));
        chk("A_b2048_xy", 64'({snap2048.x, snap2048.y}), 64'({3'd0, 3'd1}));
        chk("A_last_xy", 64'({snap_last.x, snap_last.y}), 64'({3'd7, 3'd7}));

        // Frame B: 16x16, random busy over the first 1000 beats.
        bmode = 1;
        start_frame(0);
        wait_done("B", 3 * T);
        end_checks("B");

        // Frame C: 32x32, final beat stalled for 10 cycles.
        bmode = 2;
        start_frame(1);
        wait_done("C", 2 * T);
        end_checks("C");
        chk("C_stall_cycles", 64'(stall_last), 64'(10));
        chk("C_lcu_size", 64'(lcu_size), 64'(1));
        chk("C_b1024_xy", 64'({snap1024.x, snap1024.y}), 64'({3'd1, 3'd0}));
        chk("C_last_xy", 64'({snap_last.x, snap_last.y}), 64'({3'd3, 3'd3}));

        // Frame D: reset mid-frame at beat 300, then a fresh 64x64 frame.
        bmode = 0;
        start_frame(0);
        guard = 0;
        while (beats < 300 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("D_reached_300", 64'(beats >= 300), 64'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("D_reset_outputs", 64'({img_addr, par_addr, in_en, din, sao_type, sao_band_pos,
            sao_eo_class, sao_offset, lcu_x, lcu_y, lcu_size, done}), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        start_frame(2);
        wait_done("D", 2 * T);
        end_checks("D");
        chk("D_lcu_size", 64'(lcu_size), 64'(2));
        chk("D_last_xy", 64'({snap_last.x, snap_last.y}), 64'({3'd1, 3'd1}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
